// File: rtl/rf_wb_arbiter_pkg.sv
// Shared defaults and requester identifiers for the register-file writeback arbiter.
// Imported by the arbiter, its interface and its sub-modules.
package rf_arb_pkg;

  localparam int DEF_NREQ = 3;
  localparam int DEF_XLEN = 32;
  localparam int DEF_AW   = 5;

  typedef enum logic [1:0] {
    ID_EXU = 2'd0,
    ID_LSU = 2'd1,
    ID_CSR = 2'd2
  } req_id_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback requester and register-file port bundle.
// master: requesters plus register file; slave: the arbiter.
interface rf_wb_arbiter_if
  import rf_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int XLEN = DEF_XLEN,
  parameter int AW   = DEF_AW
);
  localparam int IDW = id_width(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*XLEN-1:0] req_data;
  logic                 rf_ready;
  logic                 rf_wen;
  logic [AW-1:0]        rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic [IDW-1:0]       out_id;

  modport master (
    output req_valid, req_addr, req_data, rf_ready,
    input  req_ready, rf_wen, rf_waddr, rf_wdata, out_id
  );

  modport slave (
    input  req_valid, req_addr, req_data, rf_ready,
    output req_ready, rf_wen, rf_waddr, rf_wdata, out_id
  );
endinterface

// File: rtl/rf_wb_arbiter_reg.sv
// Enable register with asynchronous active-low reset to a parameterised value.
// Holds its value whenever en is low.
module rf_en_reg #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= RST_VAL;
    else if (en) q <= d;
  end
endmodule

// File: rtl/rf_wb_arbiter_rr_pick.sv
// Combinational round-robin pick: first valid index at or after ptr, wrapping.
// Pure logic, no state.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  g
);
  logic [IDW-1:0] idx;

  // Walk from the farthest candidate back to ptr so the nearest valid wins.
  always_comb begin
    any = 1'b0;
    g   = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (valid[idx]) begin
        any = 1'b1;
        g   = idx;
      end
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter feeding one register-file write port; 1-cycle accept-to-write latency.
// A full stage stalled by rf_ready=0 blocks all requesters; the stage loads and drains in the same cycle.
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int XLEN = DEF_XLEN,
  parameter int AW   = DEF_AW
) (
  input logic            clk,
  input logic            rst,
  rf_wb_arbiter_if.slave bus
);
  localparam int IDW = id_width(NREQ);

  logic            out_valid;
  logic [AW-1:0]   waddr_q;
  logic [XLEN-1:0] wdata_q;
  logic [IDW-1:0]  id_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  ptr_d;
  logic [IDW-1:0]  g;
  logic            any;
  logic            can_accept;
  logic            grant;
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] sel_data;

  assign can_accept = !out_valid || bus.rf_ready;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .valid (bus.req_valid),
    .ptr   (ptr_q),
    .any   (any),
    .g     (g)
  );

  // rst gates the grant so no requester sees ready while the block is held in reset.
  assign grant = rst && can_accept && any;

  always_comb begin
    bus.req_ready = '0;
    if (grant) bus.req_ready[g] = 1'b1;
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (g == IDW'(i)) begin
        sel_addr = bus.req_addr[i*AW +: AW];
        sel_data = bus.req_data[i*XLEN +: XLEN];
      end
    end
  end

  assign ptr_d = (g == IDW'(NREQ - 1)) ? '0 : g + IDW'(1);

  rf_en_reg #(.W(1)) u_vld (
    .clk (clk), .rst (rst), .en (can_accept), .d (any), .q (out_valid)
  );

  rf_en_reg #(.W(AW)) u_addr (
    .clk (clk), .rst (rst), .en (grant), .d (sel_addr), .q (waddr_q)
  );

  rf_en_reg #(.W(XLEN)) u_data (
    .clk (clk), .rst (rst), .en (grant), .d (sel_data), .q (wdata_q)
  );

  rf_en_reg #(.W(IDW)) u_id (
    .clk (clk), .rst (rst), .en (grant), .d (g), .q (id_q)
  );

  rf_en_reg #(.W(IDW)) u_ptr (
    .clk (clk), .rst (rst), .en (grant), .d (ptr_d), .q (ptr_q)
  );

  // x0 writes still occupy and drain the stage, they just never assert the enable.
  assign bus.rf_wen   = out_valid && bus.rf_ready && (waddr_q != '0);
  assign bus.rf_waddr = waddr_q;
  assign bus.rf_wdata = wdata_q;
  assign bus.out_id   = id_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed scenarios followed by a constrained random phase.
module tb_rf_wb_arbiter;
  import rf_arb_pkg::*;

  localparam int NREQ = 3;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  id;
  } ent_t;

  logic clk;
  logic rst;

  rf_wb_arbiter_if #(.NREQ(NREQ), .XLEN(32), .AW(5)) bus ();

  rf_wb_arbiter #(.NREQ(NREQ), .XLEN(32), .AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  ent_t        sb[$];
  int          mptr = 0;
  int          last_g = -1;
  logic [4:0]  a [NREQ];
  logic [31:0] d [NREQ];
  logic        pv [NREQ];
  int          exp_order [6] = '{0, 1, 2, 0, 1, 2};

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // One clock: drive at negedge, check combinational grant and staged output, update the model.
  task automatic step(input logic [2:0] v, input logic rr);
    logic mv, can, anyv;
    int   g;
    logic [2:0] er;
    ent_t e;
    @(negedge clk);
    bus.req_valid = v;
    bus.rf_ready  = rr;
    bus.req_addr  = {a[2], a[1], a[0]};
    bus.req_data  = {d[2], d[1], d[0]};
    #1;
    mv   = (sb.size() != 0);
    can  = !mv || rr;
    anyv = 1'b0;
    g    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (v[2'((mptr + k) % NREQ)]) begin
        anyv = 1'b1;
        g    = (mptr + k) % NREQ;
      end
    end
    er = (can && anyv) ? 3'(1 << g) : 3'b000;
    chk("req_ready", 64'(bus.req_ready), 64'(er));
    last_g = -1;
    for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) last_g = i;
    if (mv) begin
      e = sb[0];
      chk("rf_waddr", 64'(bus.rf_waddr), 64'(e.addr));
      chk("rf_wdata", 64'(bus.rf_wdata), 64'(e.data));
      chk("out_id",   64'(bus.out_id),   64'(e.id));
      chk("rf_wen",   64'(bus.rf_wen),   64'(rr && (e.addr != 5'd0)));
      if (rr) void'(sb.pop_front());
    end else begin
      chk("rf_wen_idle", 64'(bus.rf_wen), 64'd0);
    end
    if (can && anyv) begin
      sb.push_back('{addr: a[g], data: d[g], id: 2'(g)});
      mptr = (g + 1) % NREQ;
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      a[i] = '0; d[i] = '0; pv[i] = 1'b0;
    end
    rst = 1'b0;
    bus.req_valid = 3'b111;
    bus.rf_ready  = 1'b1;
    bus.req_addr  = '1;
    bus.req_data  = '1;
    #12;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rf_wen",    64'(bus.rf_wen),    64'd0);
    chk("rst_rf_waddr",  64'(bus.rf_waddr),  64'd0);
    chk("rst_rf_wdata",  64'(bus.rf_wdata),  64'd0);
    chk("rst_out_id",    64'(bus.out_id),    64'd0);
    @(negedge clk);
    bus.req_valid = '0;
    rst = 1'b1;

    // Single request from EXU.
    a[ID_EXU] = 5'd5; d[ID_EXU] = 32'hDEADBEEF;
    step(3'b001, 1'b1);
    chk("single_grant", 64'(last_g), 64'(ID_EXU));
    step(3'b000, 1'b1);

    // x0 write from CSR: staged, never enabled, ptr wraps to 0.
    a[ID_CSR] = 5'd0; d[ID_CSR] = 32'h1234;
    step(3'b100, 1'b1);
    chk("x0_grant", 64'(last_g), 64'(ID_CSR));
    step(3'b000, 1'b1);

    // Fairness with all requesters valid.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        a[i] = 5'(8 + 3 * k + i);
        d[i] = 32'hA000_0000 + 32'(16 * k + i);
      end
      step(3'b111, 1'b1);
      chk("grant_order", 64'(last_g), 64'(exp_order[k]));
    end
    step(3'b000, 1'b1);

    // Backpressure: stage full while rf_ready=0, LSU waits.
    a[0] = 5'd9;  d[0] = 32'hB0B0_0000;
    step(3'b001, 1'b0);
    a[1] = 5'd11; d[1] = 32'hC0C0_0001;
    for (int k = 0; k < 3; k++) begin
      step(3'b010, 1'b0);
      chk("bp_hold_data", 64'(bus.rf_wdata), 64'h0000_0000_B0B0_0000);
    end
    step(3'b010, 1'b1);
    chk("bp_release_grant", 64'(last_g), 64'd1);

    // Wrap and skip: ptr=2 with only 0 and 1 valid.
    a[0] = 5'd3; d[0] = 32'h0000_0003;
    a[1] = 5'd4; d[1] = 32'h0000_0004;
    step(3'b011, 1'b1);
    chk("wrap_g0", 64'(last_g), 64'd0);
    a[0] = 5'd6; d[0] = 32'h0000_0006;
    step(3'b011, 1'b1);
    chk("wrap_g1", 64'(last_g), 64'd1);
    step(3'b000, 1'b1);

    // Reset while a write to r7 is staged.
    a[2] = 5'd7; d[2] = 32'h7777_7777;
    step(3'b100, 1'b0);
    @(negedge clk);
    bus.req_valid = 3'b000;
    bus.rf_ready  = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midrst_rf_wen",   64'(bus.rf_wen),   64'd0);
    chk("midrst_rf_waddr", 64'(bus.rf_waddr), 64'd0);
    chk("midrst_out_id",   64'(bus.out_id),   64'd0);
    bus.rf_ready  = 1'b1;
    bus.req_valid = 3'b111;
    #1;
    chk("midrst_wen_rdy",  64'(bus.rf_wen),    64'd0);
    chk("midrst_req_rdy",  64'(bus.req_ready), 64'd0);
    sb.delete();
    mptr = 0;
    @(negedge clk);
    bus.req_valid = 3'b000;
    rst = 1'b1;
    step(3'b000, 1'b1);
    step(3'b000, 1'b1);
    for (int i = 0; i < NREQ; i++) begin
      a[i] = 5'(20 + i); d[i] = 32'h5000_0000 + 32'(i);
    end
    step(3'b111, 1'b1);
    chk("post_rst_grant", 64'(last_g), 64'd0);
    step(3'b000, 1'b1);

    // Random traffic; requesters hold their request until accepted.
    for (int n = 0; n < 80; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pv[i] && ($urandom % 2 == 0)) begin
          pv[i] = 1'b1;
          a[i]  = 5'($urandom);
          d[i]  = $urandom;
        end
      end
      step({pv[2], pv[1], pv[0]}, ($urandom % 4) != 0);
      if (last_g >= 0) pv[last_g] = 1'b0;
    end
    step(3'b000, 1'b1);
    step(3'b000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
